mac_unit_bitserial_acc: RTL
===========================

MAC_UNIT_BITSERIAL_ACC -- requirements
Module: mac_unit_bitserial_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed activation width.
REQ-002 SHALL have parameter VEC_LENGTH, default 8, adder-tree inputs; power of two, at least 2.
REQ-003 SHALL have parameter SUM_ACT_WIDTH, default 12, width of sum_act and column value.
REQ-004 SHALL have parameter ACC_WIDTH, default 20, width of accumulator and result.
REQ-005 SHALL have parameter MAX_COLS, default 8, maximum weight bit-columns per dot product.
REQ-006 SHALL have ports: clk  input  1  sole clock, rising edge; reset  input  1  synchronous, active-high.
REQ-007 SHALL have ports: adder_in  input  VEC_LENGTH x DATA_WIDTH signed  pre-gated activations for one column.
REQ-008 SHALL have ports: sum_act  input  SUM_ACT_WIDTH signed  group activation sum; is_msb  input  1  column is weight MSB (first); is_skip_zero  input  1  column mode; in_last  input  1  final column.
REQ-009 SHALL have ports: in_valid  input  1; in_ready  output  1; out_valid  output  1; out_ready  input  1; result  output  ACC_WIDTH signed; err  output  1  sticky protocol error.

Function
REQ-010 SHALL accept a column when in_valid and in_ready are both high in the same cycle.
REQ-011 SHALL compute tree = sign-extended sum of all adder_in, width DATA_WIDTH+log2(VEC_LENGTH).
REQ-012 SHALL compute col_val per {is_msb,is_skip_zero}: 11 -> -tree; 10 -> tree-sum_act; 01 -> tree; 00 -> sum_act-tree; all in SUM_ACT_WIDTH two's complement, wrapping.
REQ-013 SHALL register col_val, in_last, is_msb into stage 1 (s1) on acceptance.
REQ-014 SHALL run an accumulator FSM with states IDLE and ACC.
REQ-015 In IDLE, an s1 column with is_msb=1 SHALL load acc = sign-extend(col_val) and go to ACC, or to IDLE if last.
REQ-016 In ACC, an s1 column with is_msb=0 SHALL update acc = (acc <<< 1) + sign-extend(col_val), wrapping at ACC_WIDTH.
REQ-017 A last column SHALL copy the final accumulated value to the result register, set out_valid, and return the FSM to IDLE the same cycle.
REQ-018 Latency SHALL be 2 cycles from acceptance of the last column to out_valid high.
REQ-019 result SHALL hold stable while out_valid=1 and out_ready=0; out_valid SHALL clear on out_valid and out_ready unless a new result loads the same cycle.
REQ-020 s1 SHALL stall only when it holds a last column and out_valid=1 and out_ready=0.
REQ-021 in_ready SHALL equal (s1 empty) or (s1 not stalled), so back-to-back dot products run with no bubble.
REQ-022 An s1 column with is_msb=0 in IDLE SHALL be discarded and set err.
REQ-023 An s1 column with is_msb=1 in ACC SHALL set err and restart accumulation from that column.
REQ-024 A column count exceeding MAX_COLS SHALL set err and continue accumulating.
REQ-025 err SHALL remain high until reset.

Reset
REQ-026 Reset SHALL drive FSM=IDLE, s1 empty, acc=0, column count=0, result=0, out_valid=0, err=0, with in_ready=1 the following cycle.
REQ-027 Reset mid-accumulation SHALL discard all partial state; no result for that dot product is ever produced.

Configuration
REQ-028 Macro MAC_SKIP_ZERO_EN defined SHALL implement all four REQ-012 modes.
REQ-029 Without MAC_SKIP_ZERO_EN, is_skip_zero SHALL be ignored and treated as 0; only modes 10 and 00 are built; ports are unchanged.

Structure
REQ-030 Package bitsim_mac_pkg SHALL hold the FSM state enum, the mode-select encoding constants, and the clog2-based width helper.
REQ-031 The tree SHALL be a sub-module adder_tree_pow2, combinational, parametrised by DATA_WIDTH and VEC_LENGTH, with log2(VEC_LENGTH) levels.

Verification (DATA_WIDTH=8, VEC_LENGTH=8, defaults)
REQ-032 Single column: msb=1, skip=1, last=1, all adder_in=1 -> result=-8, out_valid 2 cycles after acceptance.
REQ-033 Two columns, skip=1: msb column all 0, then last column all 3 -> result=24.
REQ-034 Diff mode: sum_act=100, all adder_in=5; msb column then last column -> column values -60 and 60, result=-60.
REQ-035 Backpressure: two dot products with out_ready=0 -> in_ready drops while s1 holds the second last column; release out_ready -> both results delivered in order, unchanged.
REQ-036 Reset asserted after the 2nd of 4 columns, then a fresh single-column 32-valued dot product -> only result=32 appears.
REQ-037 Protocol error: first column with is_msb=0 -> column discarded, err=1 persists; a subsequent valid dot product is still correct.

Source files
------------

// File: rtl/bitsim_mac_pkg.sv
// Shared definitions for the bit-serial MAC accumulator: FSM state,
// column-mode encodings {is_msb, is_skip_zero} and a width helper.
package bitsim_mac_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    localparam logic [1:0] MODE_MSB_SKIP = 2'b11;
    localparam logic [1:0] MODE_MSB_DIFF = 2'b10;
    localparam logic [1:0] MODE_LSB_SKIP = 2'b01;
    localparam logic [1:0] MODE_LSB_DIFF = 2'b00;

    // ceil(log2(n)) with a floor of one bit, usable in constant expressions
    function automatic int clog2_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_tree_pow2.sv
// Signed adder tree: sums VEC_LENGTH activations in log2(VEC_LENGTH) pairwise levels.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module adder_tree_pow2
    import bitsim_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8
) (
    input  logic        [VEC_LENGTH-1:0][DATA_WIDTH-1:0]      adder_in,
    output logic signed [DATA_WIDTH+clog2_w(VEC_LENGTH)-1:0] tree_sum
);

    localparam int LEVELS    = clog2_w(VEC_LENGTH);
    localparam int SUM_WIDTH = DATA_WIDTH + LEVELS;

    // Every node carries the full output width so no level can overflow.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic signed [SUM_WIDTH-1:0] node [VEC_LENGTH >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_in
                assign node[i] = SUM_WIDTH'($signed(adder_in[i]));
            end
        end else begin : g_sum
            for (genvar i = 0; i < (VEC_LENGTH >> l); i++) begin : g_add
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign tree_sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/mac_unit_bitserial_acc.sv
// Bit-serial MAC: folds weight bit-columns MSB-first into a signed dot product (MAC_SKIP_ZERO_EN adds skip-zero modes).
// Latency: result valid 2 cycles after the last column is accepted; back-to-back dot products without bubbles.
// Backpressure: a held result stalls stage 1 only when it carries a last column; in_ready drops while stalled.
module mac_unit_bitserial_acc
    import bitsim_mac_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 8,
    parameter int SUM_ACT_WIDTH = 12,
    parameter int ACC_WIDTH     = 20,
    parameter int MAX_COLS      = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic        [VEC_LENGTH-1:0][DATA_WIDTH-1:0] adder_in,
    input  logic signed [SUM_ACT_WIDTH-1:0]       sum_act,
    input  logic                                  is_msb,
    input  logic                                  is_skip_zero,
    input  logic                                  in_last,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [ACC_WIDTH-1:0]           result,
    output logic                                  err
);

    localparam int TREE_W = DATA_WIDTH + clog2_w(VEC_LENGTH);
    localparam int CNT_W  = clog2_w(MAX_COLS + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_COLS);

    typedef struct packed {
        logic                     last;
        logic                     msb;
        logic [SUM_ACT_WIDTH-1:0] col;
    } s1_t;

    logic signed [TREE_W-1:0]        tree_sum;
    logic signed [SUM_ACT_WIDTH-1:0] tree_ext;
    logic signed [SUM_ACT_WIDTH-1:0] col_val;
    s1_t                             s1_dat;
    logic                            s1_vld;
    logic                            s1_stall;
    logic                            s1_fire;
    logic                            in_fire;
    acc_state_e                      state;
    logic signed [ACC_WIDTH-1:0]     acc;
    logic signed [ACC_WIDTH-1:0]     col_ext;
    logic signed [ACC_WIDTH-1:0]     acc_nxt;
    logic        [CNT_W-1:0]         col_cnt;
    logic        [CNT_W-1:0]         cnt_inc;

    adder_tree_pow2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LENGTH (VEC_LENGTH)
    ) u_tree (
        .adder_in (adder_in),
        .tree_sum (tree_sum)
    );

    assign tree_ext = SUM_ACT_WIDTH'(tree_sum);

`ifdef MAC_SKIP_ZERO_EN
    always_comb begin
        col_val = '0;
        case ({is_msb, is_skip_zero})
            MODE_MSB_SKIP: col_val = -tree_ext;
            MODE_MSB_DIFF: col_val = tree_ext - sum_act;
            MODE_LSB_SKIP: col_val = tree_ext;
            MODE_LSB_DIFF: col_val = sum_act - tree_ext;
        endcase
    end
`else
    logic unused_skip;
    assign unused_skip = is_skip_zero;

    always_comb begin
        col_val = '0;
        if (is_msb) col_val = tree_ext - sum_act;
        else        col_val = sum_act - tree_ext;
    end
`endif

    // A last column cannot retire while the previous result is still unclaimed.
    assign s1_stall = s1_vld && s1_dat.last && out_valid && !out_ready;
    assign s1_fire  = s1_vld && !s1_stall;
    assign in_ready = !s1_vld || !s1_stall;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (in_fire) begin
            s1_vld <= 1'b1;
            s1_dat <= '{last: in_last, msb: is_msb, col: col_val};
        end else if (s1_fire) begin
            s1_vld <= 1'b0;
        end
    end

    assign col_ext = ACC_WIDTH'($signed(s1_dat.col));
    assign acc_nxt = (acc <<< 1) + col_ext;
    assign cnt_inc = (col_cnt > CNT_LIMIT) ? col_cnt : col_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            col_cnt   <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (s1_fire) begin
                if (s1_dat.msb) begin
                    // An MSB column always starts a fresh dot product; mid-product it also flags a fault.
                    if (state == ST_ACC) err <= 1'b1;
                    acc     <= col_ext;
                    col_cnt <= CNT_W'(1);
                    if (s1_dat.last) begin
                        result    <= col_ext;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state     <= ST_ACC;
                    end
                end else if (state == ST_IDLE) begin
                    err <= 1'b1;
                end else begin
                    acc     <= acc_nxt;
                    col_cnt <= cnt_inc;
                    if (cnt_inc > CNT_LIMIT) err <= 1'b1;
                    if (s1_dat.last) begin
                        result    <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule
